// File: rtl/datapath_alu_sequencer_if.sv
// datapath_alu_sequencer_if: handshake and strobe bundle between the sequencer and the bus datapath
interface datapath_alu_sequencer_if #(parameter int CNT_W = 16);
  logic             i_run;
  logic             i_mem_ready;
  logic [31:0]      i_ir;
  logic             o_pc_out, o_mar_in, o_z_in, o_zlo_out, o_pc_in, o_inc_pc;
  logic             o_read, o_mdr_in, o_mdr_out, o_ir_in, o_y_in;
  logic [15:0]      o_r_out, o_r_in;
  logic [4:0]       o_alu_ctl;
  logic             o_busy, o_done, o_fault;
  logic [CNT_W-1:0] o_instr_count;
  modport master (
    input  i_run, i_mem_ready, i_ir,
    output o_pc_out, o_mar_in, o_z_in, o_zlo_out, o_pc_in, o_inc_pc, o_read, o_mdr_in,
           o_mdr_out, o_ir_in, o_y_in, o_r_out, o_r_in, o_alu_ctl, o_busy, o_done, o_fault,
           o_instr_count
  );
  modport slave (
    output i_run, i_mem_ready, i_ir,
    input  o_pc_out, o_mar_in, o_z_in, o_zlo_out, o_pc_in, o_inc_pc, o_read, o_mdr_in,
           o_mdr_out, o_ir_in, o_y_in, o_r_out, o_r_in, o_alu_ctl, o_busy, o_done, o_fault,
           o_instr_count
  );
endinterface

// File: rtl/datapath_alu_sequencer.sv
// datapath_alu_sequencer: fetch/R-format execute control FSM with registered Moore strobes
module datapath_alu_sequencer #(
  parameter logic [4:0] OP_RMAX     = 5'd11,
  parameter int         MEM_TIMEOUT = 8,
  parameter int         CNT_W       = 16
) (
  input logic clk,
  input logic rst_n,
  datapath_alu_sequencer_if.master bus
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, FAULT} state_t;
  state_t r_state, w_nxt;
  logic [4:0] r_op, w_op;
  logic [3:0] r_ra, r_rb, r_rc, w_ra, w_rb, w_rc;
  logic [WW-1:0] r_wait;
  logic w_legal_t3;
  logic w_unused_ir;
  assign w_unused_ir = ^bus.i_ir[14:0];
  // IR fields are captured on the T2->T3 edge and held for the rest of the instruction
  always_comb begin
    {w_op, w_ra, w_rb, w_rc} = r_state == T2 ? bus.i_ir[31:15] : {r_op, r_ra, r_rb, r_rc};
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  w_nxt = bus.i_run ? T0 : IDLE;
      T0:    w_nxt = T1;
      T1:    w_nxt = bus.i_mem_ready ? T2 : r_wait == WW'(MEM_TIMEOUT - 1) ? FAULT : T1;
      T2:    w_nxt = T3;
      T3:    w_nxt = r_op > OP_RMAX ? FAULT : T4;
      T4:    w_nxt = T5;
      T5:    w_nxt = bus.i_run ? T0 : IDLE;
      FAULT: w_nxt = FAULT;
    endcase
    w_legal_t3 = w_nxt == T3 && w_op <= OP_RMAX;
  end
  // Outputs are decoded from the next state so they appear registered in the state they belong to
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state           <= IDLE;
      {r_op, r_ra, r_rb, r_rc} <= '0;
      r_wait            <= '0;
      bus.o_pc_out      <= 1'b0;
      bus.o_mar_in      <= 1'b0;
      bus.o_inc_pc      <= 1'b0;
      bus.o_z_in        <= 1'b0;
      bus.o_zlo_out     <= 1'b0;
      bus.o_pc_in       <= 1'b0;
      bus.o_read        <= 1'b0;
      bus.o_mdr_in      <= 1'b0;
      bus.o_mdr_out     <= 1'b0;
      bus.o_ir_in       <= 1'b0;
      bus.o_y_in        <= 1'b0;
      bus.o_r_out       <= '0;
      bus.o_r_in        <= '0;
      bus.o_alu_ctl     <= '0;
      bus.o_busy        <= 1'b0;
      bus.o_done        <= 1'b0;
      bus.o_fault       <= 1'b0;
      bus.o_instr_count <= '0;
    end else begin
      r_state           <= w_nxt;
      {r_op, r_ra, r_rb, r_rc} <= {w_op, w_ra, w_rb, w_rc};
      r_wait            <= r_state == T1 ? r_wait + 1'b1 : '0;
      bus.o_pc_out      <= w_nxt == T0;
      bus.o_mar_in      <= w_nxt == T0;
      bus.o_inc_pc      <= w_nxt == T0;
      bus.o_z_in        <= w_nxt == T0 || w_nxt == T4;
      bus.o_zlo_out     <= w_nxt == T1 || w_nxt == T5;
      bus.o_pc_in       <= w_nxt == T1 && r_state == T0;
      bus.o_read        <= w_nxt == T1;
      bus.o_mdr_in      <= w_nxt == T1;
      bus.o_mdr_out     <= w_nxt == T2;
      bus.o_ir_in       <= w_nxt == T2;
      bus.o_y_in        <= w_legal_t3;
      bus.o_r_out       <= w_legal_t3 ? 16'h1 << w_rb : w_nxt == T4 ? 16'h1 << w_rc : 16'h0;
      bus.o_r_in        <= w_nxt == T5 ? 16'h1 << w_ra : 16'h0;
      bus.o_alu_ctl     <= w_nxt == T4 ? {w_op[3:0], 1'b0} : 5'd0;
      bus.o_busy        <= w_nxt != IDLE && w_nxt != FAULT;
      bus.o_done        <= w_nxt == T5;
      bus.o_fault       <= w_nxt == FAULT;
      bus.o_instr_count <= bus.o_instr_count + CNT_W'(r_state == T5);
    end
endmodule

// File: tb/tb_datapath_alu_sequencer.sv
// tb_datapath_alu_sequencer: directed stimulus, spec-level reference model compared every cycle
module tb_datapath_alu_sequencer;
  localparam int MEM_TIMEOUT = 8;
  localparam int OP_RMAX = 11;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int checks = 0;
  int errors = 0;
  datapath_alu_sequencer_if #(.CNT_W(16)) bus();
  datapath_alu_sequencer #(.OP_RMAX(5'd11), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;

  // Reference model: phase -1 idle, 0..5 = T0..T5, 6 = fault; m_wait counts T1 cycles incl. current
  int m_ph, m_wait;
  logic [4:0] m_op;
  logic [3:0] m_ra, m_rb, m_rc;
  logic [15:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= -1;
      m_wait <= 0;
      m_cnt <= '0;
      {m_op, m_ra, m_rb, m_rc} <= '0;
    end else if (m_ph == -1) m_ph <= bus.i_run ? 0 : -1;
    else if (m_ph == 0) begin
      m_ph <= 1;
      m_wait <= 1;
    end else if (m_ph == 1) begin
      m_wait <= m_wait + 1;
      m_ph <= bus.i_mem_ready ? 2 : (m_wait == MEM_TIMEOUT ? 6 : 1);
    end else if (m_ph == 2) begin
      m_ph <= 3;
      {m_op, m_ra, m_rb, m_rc} <= bus.i_ir[31:15];
    end else if (m_ph == 3) m_ph <= (int'(m_op) > OP_RMAX) ? 6 : 4;
    else if (m_ph == 4) m_ph <= 5;
    else if (m_ph == 5) begin
      m_cnt <= m_cnt + 16'd1;
      m_ph <= bus.i_run ? 0 : -1;
    end
  end

  function automatic logic [66:0] outs();
    return {bus.o_pc_out, bus.o_mar_in, bus.o_z_in, bus.o_zlo_out, bus.o_pc_in, bus.o_inc_pc,
            bus.o_read, bus.o_mdr_in, bus.o_mdr_out, bus.o_ir_in, bus.o_y_in, bus.o_r_out,
            bus.o_r_in, bus.o_alu_ctl, bus.o_busy, bus.o_done, bus.o_fault, bus.o_instr_count};
  endfunction

  function automatic logic [66:0] model_outs();
    logic legal, t0, t1, t2;
    logic [15:0] ro, ri;
    logic [4:0] alu;
    legal = int'(m_op) <= OP_RMAX;
    t0 = m_ph == 0;
    t1 = m_ph == 1;
    t2 = m_ph == 2;
    ro = (m_ph == 3 && legal) ? 16'h1 << m_rb : (m_ph == 4 ? 16'h1 << m_rc : 16'h0);
    ri = m_ph == 5 ? 16'h1 << m_ra : 16'h0;
    alu = m_ph == 4 ? 5'(m_op[3:0] * 2) : 5'd0;
    return {t0, t0, t0 || m_ph == 4, t1 || m_ph == 5, t1 && m_wait == 1, t0,
            t1, t1, t2, t2, m_ph == 3 && legal, ro,
            ri, alu, m_ph >= 0 && m_ph <= 5, m_ph == 5, m_ph == 6, m_cnt};
  endfunction

  initial forever begin
    @(negedge clk);
    checks++;
    if (outs() !== model_outs()) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, outs(), model_outs());
    end
    checks++;
    if ($countones({bus.o_pc_out, bus.o_zlo_out, bus.o_mdr_out, |bus.o_r_out}) > 1) begin
      errors++;
      $display("FAIL bus_drivers t=%0t got=%b exp=at_most_one", $time,
               {bus.o_pc_out, bus.o_zlo_out, bus.o_mdr_out, |bus.o_r_out});
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Issues one instruction with `stall` MemReady=0 cycles in T1; stops at Done or Fault
  task automatic one_instr(input logic [31:0] ir, input int stall,
                           output int lat, output int t1, output int pcin, output int yin);
    lat = 0; t1 = 0; pcin = 0; yin = 0;
    bus.i_ir = ir;
    bus.i_run = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      t1 += int'(bus.o_read);
      pcin += int'(bus.o_pc_in);
      yin += int'(bus.o_y_in);
      bus.i_mem_ready = t1 > stall;
      if (bus.o_done || bus.o_fault) begin
        lat = n;
        bus.i_run = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_fault", 32'(bus.o_fault), 0);
    chk("reset_count", 32'(bus.o_instr_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] prog [3];
  int lat, t1, pcin, yin, nd;
  int d_at [3];

  initial begin
    bus.i_run = 1'b0;
    bus.i_mem_ready = 1'b0;
    bus.i_ir = '0;
    prog[0] = 32'h28918000;
    prog[1] = 32'h5B5B8000;
    prog[2] = 32'h00000000;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_busy", 32'(bus.o_busy), 0);
    chk("idle_count", 32'(bus.o_instr_count), 0);
    // single instruction, MemReady ready immediately
    bus.i_run = 1'b1; bus.i_mem_ready = 1'b1; bus.i_ir = 32'h28918000;
    @(negedge clk);
    chk("t0_pc_out", 32'(bus.o_pc_out), 1);
    chk("t0_inc_pc", 32'(bus.o_inc_pc), 1);
    @(negedge clk);
    chk("t1_pc_in", 32'(bus.o_pc_in), 1);
    @(negedge clk);
    chk("t2_ir_in", 32'(bus.o_ir_in), 1);
    @(negedge clk);
    chk("t3_r_out", 32'(bus.o_r_out), 32'h0004);
    chk("t3_y_in", 32'(bus.o_y_in), 1);
    @(negedge clk);
    chk("t4_r_out", 32'(bus.o_r_out), 32'h0008);
    chk("t4_alu", 32'(bus.o_alu_ctl), 32'b01010);
    @(negedge clk);
    chk("t5_r_in", 32'(bus.o_r_in), 32'h0002);
    chk("t5_done", 32'(bus.o_done), 1);
    bus.i_run = 1'b0;
    @(negedge clk);
    chk("first_count", 32'(bus.o_instr_count), 1);
    chk("first_idle", 32'(bus.o_busy), 0);
    // three wait cycles in T1
    bus.i_mem_ready = 1'b0;
    one_instr(32'h5B5B8000, 3, lat, t1, pcin, yin);
    chk("wait3_latency", 32'(lat), 9);
    chk("wait3_t1_len", 32'(t1), 4);
    chk("wait3_pc_in", 32'(pcin), 1);
    // MemReady on the last allowed T1 cycle still completes
    one_instr(32'h5B5B8000, MEM_TIMEOUT - 1, lat, t1, pcin, yin);
    chk("edge_latency", 32'(lat), 13);
    chk("edge_t1_len", 32'(t1), 8);
    chk("edge_no_fault", 32'(bus.o_fault), 0);
    @(negedge clk);
    chk("edge_count", 32'(bus.o_instr_count), 3);
    // illegal opcode faults out of T3 without retiring
    one_instr(32'hF8000000, 0, lat, t1, pcin, yin);
    chk("illegal_latency", 32'(lat), 5);
    chk("illegal_y_in", 32'(yin), 0);
    chk("illegal_fault", 32'(bus.o_fault), 1);
    chk("illegal_count", 32'(bus.o_instr_count), 3);
    bus.i_run = 1'b1;
    repeat (4) @(negedge clk);
    chk("fault_sticky", 32'(bus.o_fault), 1);
    chk("fault_busy", 32'(bus.o_busy), 0);
    bus.i_run = 1'b0;
    do_reset();
    // memory timeout
    one_instr(32'h28918000, 1000, lat, t1, pcin, yin);
    chk("timeout_latency", 32'(lat), 10);
    chk("timeout_t1_len", 32'(t1), MEM_TIMEOUT);
    chk("timeout_fault", 32'(bus.o_fault), 1);
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 32'(bus.o_fault), 1);
    do_reset();
    // back-to-back with Run dropped in T2 of the third instruction
    nd = 0;
    bus.i_ir = prog[0]; bus.i_mem_ready = 1'b1; bus.i_run = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 15) bus.i_run = 1'b0;
      if (bus.o_done) begin
        if (nd < 3) d_at[nd] = n;
        nd++;
        if (nd < 3) bus.i_ir = prog[nd];
      end
    end
    chk("b2b_dones", 32'(nd), 3);
    chk("b2b_done0", 32'(d_at[0]), 6);
    chk("b2b_done1", 32'(d_at[1]), 12);
    chk("b2b_done2", 32'(d_at[2]), 18);
    chk("b2b_idle", 32'(bus.o_busy), 0);
    chk("b2b_count", 32'(bus.o_instr_count), 3);
    // asynchronous reset in T4
    bus.i_run = 1'b1; bus.i_ir = 32'h28918000;
    repeat (5) @(negedge clk);
    chk("pre_reset_t4_z_in", 32'(bus.o_z_in), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(|outs()), 0);
    bus.i_run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
